// File: rtl/riscv_vector_mem_adapter_if.sv
// Narrow L1 data-bus beat interface between the vector memory adapter (master)
// and the L1 data port (slave).
interface riscv_vector_mem_adapter_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned BUS_W = 128
);
    logic               bus_valid;
    logic               bus_ready;
    logic [XLEN-1:0]    bus_addr;
    logic               bus_we;
    logic [BUS_W-1:0]   bus_wdata;
    logic [BUS_W/8-1:0] bus_wstrb;
    logic               bus_rvalid;
    logic [BUS_W-1:0]   bus_rdata;

    modport master (
        output bus_valid, bus_addr, bus_we, bus_wdata, bus_wstrb,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_addr, bus_we, bus_wdata, bus_wstrb,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/riscv_vector_mem_adapter.sv
// Splits one VLEN-wide vector load/store into BUS_W-wide beats, one beat in
// flight at a time, and reassembles load data into a VLEN-wide word.
module riscv_vector_mem_adapter #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned VLEN  = 512,
    parameter int unsigned BUS_W = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     vec_mem_addr_i,
    input  logic [VLEN-1:0]     vec_mem_wdata_i,
    input  logic                vec_mem_req_i,
    input  logic                vec_mem_we_i,
    input  logic [VLEN/8-1:0]   vec_mem_be_i,
    output logic [VLEN-1:0]     vec_mem_rdata_o,
    output logic                vec_mem_ready_o,
    output logic                busy_o,
    riscv_vector_mem_adapter_if.master bus
);
    localparam int unsigned BEATS     = VLEN / BUS_W;
    localparam int unsigned STRB_W    = BUS_W / 8;
    localparam int unsigned VEC_BYTES = VLEN / 8;
    localparam int unsigned KW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned BOFF      = $clog2(STRB_W);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_e;

    state_e              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [XLEN-1:0]     base_q, base_d;
    logic                we_q, we_d;
    logic [VEC_BYTES-1:0] be_q, be_d;
    logic [VLEN-1:0]     wdata_q, wdata_d;
    logic [VLEN-1:0]     buf_q, buf_d;
    logic [VLEN-1:0]     rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                bus_valid_q, bus_valid_d;
    logic [XLEN-1:0]     bus_addr_q, bus_addr_d;
    logic                bus_we_q, bus_we_d;
    logic [BUS_W-1:0]    bus_wdata_q, bus_wdata_d;
    logic [STRB_W-1:0]   bus_wstrb_q, bus_wstrb_d;
    logic [KW:0]         hit;

    // {found, index} of the first beat at or after start with a non-zero strobe slice
    function automatic logic [KW:0] find_beat(input logic [VEC_BYTES-1:0] be,
                                              input int unsigned start);
        logic [KW:0] r;
        r = '0;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (!r[KW] && (i >= start) && (|be[i*STRB_W +: STRB_W])) begin
                r = {1'b1, KW'(i)};
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        base_d  = base_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        hit     = '0;

        case (state_q)
            IDLE: begin
                if (vec_mem_req_i) begin
                    base_d  = vec_mem_addr_i & ~XLEN'(VEC_BYTES - 1);
                    we_d    = vec_mem_we_i;
                    be_d    = vec_mem_be_i;
                    wdata_d = vec_mem_wdata_i;
                    buf_d   = '0;
                    k_d     = '0;
                    state_d = ISSUE;
                    if (vec_mem_we_i) begin
                        hit = find_beat(vec_mem_be_i, 0);
                        k_d = hit[KW-1:0];
                        if (!hit[KW]) state_d = DONE;
                    end
                end
            end
            ISSUE: begin
                if (bus_valid_q && bus.bus_ready) begin
                    if (!we_q) begin
                        state_d = RESP;
                    end else begin
                        hit = find_beat(be_q, 32'(k_q) + 32'd1);
                        if (hit[KW]) k_d = hit[KW-1:0];
                        else         state_d = DONE;
                    end
                end
            end
            RESP: begin
                if (bus.bus_rvalid) begin
                    buf_d[32'(k_q)*BUS_W +: BUS_W] = bus.bus_rdata;
                    if (k_q == KW'(BEATS - 1)) begin
                        rdata_d = buf_d;
                        state_d = DONE;
                    end else begin
                        k_d     = KW'(k_q + KW'(1));
                        state_d = ISSUE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next-state view so they line up with the state
        ready_d     = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        bus_valid_d = (state_d == ISSUE);
        bus_addr_d  = '0;
        bus_we_d    = 1'b0;
        bus_wdata_d = '0;
        bus_wstrb_d = '0;
        if (bus_valid_d) begin
            bus_addr_d  = base_d + (XLEN'(k_d) << BOFF);
            bus_we_d    = we_d;
            bus_wdata_d = wdata_d[32'(k_d)*BUS_W +: BUS_W];
            bus_wstrb_d = be_d[32'(k_d)*STRB_W +: STRB_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            base_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_we_q    <= 1'b0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            base_q      <= base_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            bus_valid_q <= bus_valid_d;
            bus_addr_q  <= bus_addr_d;
            bus_we_q    <= bus_we_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
        end
    end

    assign vec_mem_rdata_o = rdata_q;
    assign vec_mem_ready_o = ready_q;
    assign busy_o          = busy_q;
    assign bus.bus_valid   = bus_valid_q;
    assign bus.bus_addr    = bus_addr_q;
    assign bus.bus_we      = bus_we_q;
    assign bus.bus_wdata   = bus_wdata_q;
    assign bus.bus_wstrb   = bus_wstrb_q;
endmodule

// File: tb/tb_riscv_vector_mem_adapter.sv
// Scoreboard bench for riscv_vector_mem_adapter: expected beats and completions
// are queued by the stimulus and consumed by an independent monitor.
module tb_riscv_vector_mem_adapter;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned VLEN  = 512;
    localparam int unsigned BUS_W = 128;

    typedef struct {
        logic [XLEN-1:0]    addr;
        logic               we;
        logic [BUS_W-1:0]   wdata;
        logic [BUS_W/8-1:0] wstrb;
        bit                 cmp_data;
    } beat_t;

    typedef struct {
        logic [VLEN-1:0] rdata;
        int              cyc;
    } done_t;

    logic              clk;
    logic              rst;
    logic [XLEN-1:0]   vec_mem_addr;
    logic [VLEN-1:0]   vec_mem_wdata;
    logic              vec_mem_req;
    logic              vec_mem_we;
    logic [VLEN/8-1:0] vec_mem_be;
    logic [VLEN-1:0]   vec_mem_rdata;
    logic              vec_mem_ready;
    logic              busy;

    riscv_vector_mem_adapter_if #(.XLEN(XLEN), .BUS_W(BUS_W)) bus_if ();

    riscv_vector_mem_adapter #(.XLEN(XLEN), .VLEN(VLEN), .BUS_W(BUS_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .vec_mem_addr_i  (vec_mem_addr),
        .vec_mem_wdata_i (vec_mem_wdata),
        .vec_mem_req_i   (vec_mem_req),
        .vec_mem_we_i    (vec_mem_we),
        .vec_mem_be_i    (vec_mem_be),
        .vec_mem_rdata_o (vec_mem_rdata),
        .vec_mem_ready_o (vec_mem_ready),
        .busy_o          (busy),
        .bus             (bus_if)
    );

    beat_t exp_beats[$];
    done_t exp_done[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    cap;
    logic [31:0] data_tag;
    int    rsp_cnt = 0;
    int    rsp_limit = 32'h7fff_ffff;
    int    spur_req = 0;
    int    spur_done = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [VLEN-1:0] exp_load(input logic [31:0] tag);
        logic [VLEN-1:0] r;
        for (int k = 0; k < 4; k++) r[k*BUS_W +: BUS_W] = {4{tag + 32'(k)}};
        return r;
    endfunction

    function automatic logic [VLEN-1:0] mk_wdata(input logic [31:0] seed);
        logic [VLEN-1:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = seed + 32'(i);
        return r;
    endfunction

    task automatic push_beat(input logic [XLEN-1:0] a, input logic we,
                             input logic [BUS_W-1:0] wd, input logic [BUS_W/8-1:0] ws,
                             input bit cmp);
        beat_t b;
        b.addr = a; b.we = we; b.wdata = wd; b.wstrb = ws; b.cmp_data = cmp;
        exp_beats.push_back(b);
    endtask

    task automatic push_load_beats(input logic [XLEN-1:0] base, input int n);
        for (int k = 0; k < n; k++) push_beat(base + 64'(k*16), 1'b0, '0, '0, 1'b0);
    endtask

    task automatic push_done(input logic [VLEN-1:0] rd, input int c);
        done_t d;
        d.rdata = rd; d.cyc = c;
        exp_done.push_back(d);
    endtask

    task automatic drive_req(input logic [XLEN-1:0] a, input logic we,
                             input logic [VLEN-1:0] wd, input logic [VLEN/8-1:0] be);
        vec_mem_addr = a; vec_mem_we = we; vec_mem_wdata = wd; vec_mem_be = be;
        vec_mem_req = 1'b1;
    endtask

    task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while ((exp_beats.size() != 0 || exp_done.size() != 0 || busy) && n < max) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL %s_timeout: got %0d beats %0d completions pending expected 0",
                     name, exp_beats.size(), exp_done.size());
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin @(posedge clk); #1; end
    endtask

    // Memory model: answers each accepted read beat one cycle later; can inject stray rvalid
    initial begin
        logic [XLEN-1:0] a;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = '0;
        forever begin
            @(negedge clk);
            if (spur_req != spur_done) begin
                spur_done++;
                @(posedge clk); #1;
                bus_if.bus_rvalid = 1'b1;
                bus_if.bus_rdata  = {4{32'hDEAD_BEEF}};
                @(posedge clk); #1;
                bus_if.bus_rvalid = 1'b0;
            end else if (!rst && bus_if.bus_valid && bus_if.bus_ready && !bus_if.bus_we
                         && rsp_cnt < rsp_limit) begin
                a = bus_if.bus_addr;
                rsp_cnt++;
                @(posedge clk); #1;
                bus_if.bus_rvalid = 1'b1;
                bus_if.bus_rdata  = {4{data_tag + 32'(a[5:4])}};
                @(posedge clk); #1;
                bus_if.bus_rvalid = 1'b0;
            end
        end
    end

    // Monitor: every presented beat and every completion pulse is matched to the queues
    initial begin
        beat_t b;
        done_t d;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus_if.bus_valid) begin
                    checks++;
                    if (exp_beats.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got addr=%h we=%b expected no beat",
                                 bus_if.bus_addr, bus_if.bus_we);
                    end else begin
                        b = exp_beats[0];
                        if (bus_if.bus_addr !== b.addr || bus_if.bus_we !== b.we ||
                            (b.cmp_data && (bus_if.bus_wdata !== b.wdata ||
                                            bus_if.bus_wstrb !== b.wstrb))) begin
                            errors++;
                            $display("FAIL beat: got addr=%h we=%b wdata=%h wstrb=%h expected addr=%h we=%b wdata=%h wstrb=%h",
                                     bus_if.bus_addr, bus_if.bus_we, bus_if.bus_wdata, bus_if.bus_wstrb,
                                     b.addr, b.we, b.wdata, b.wstrb);
                        end
                        if (bus_if.bus_ready) void'(exp_beats.pop_front());
                    end
                end
                if (vec_mem_ready) begin
                    checks++;
                    if (exp_done.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
                    end else begin
                        d = exp_done.pop_front();
                        if (vec_mem_rdata !== d.rdata || (d.cyc >= 0 && cyc != d.cyc)) begin
                            errors++;
                            $display("FAIL completion: got cycle %0d rdata %h expected cycle %0d rdata %h",
                                     cyc, vec_mem_rdata, d.cyc, d.rdata);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [VLEN-1:0]   w;
        logic [VLEN/8-1:0] be;
        logic [VLEN-1:0]   last_load;

        rst = 1'b1;
        vec_mem_req = 1'b0; vec_mem_we = 1'b0; vec_mem_addr = '0;
        vec_mem_wdata = '0; vec_mem_be = '0;
        bus_if.bus_ready = 1'b1;
        data_tag = 32'hA0;
        #1;
        chk("reset_rdata", vec_mem_rdata, '0);
        chk("reset_ready", VLEN'(vec_mem_ready), '0);
        chk("reset_busy", VLEN'(busy), '0);
        chk("reset_bus_valid", VLEN'(bus_if.bus_valid), '0);
        chk("reset_bus_addr", VLEN'(bus_if.bus_addr), '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Load at an unaligned address; minimum latency
        @(posedge clk); #1;
        cap = cyc + 1;
        push_load_beats(64'h1040, 4);
        push_done(exp_load(32'hA0), cap + 8);
        drive_req(64'h1043, 1'b0, '0, '1);
        @(posedge clk); #1;
        vec_mem_req = 1'b0;
        wait_drain("load1", 60);
        last_load = exp_load(32'hA0);

        // Full store with a 3-cycle stall on beat 1; request fields garbled after capture
        w = mk_wdata(32'hC0DE_0000);
        @(posedge clk); #1;
        cap = cyc + 1;
        for (int k = 0; k < 4; k++) push_beat(64'h2000 + 64'(k*16), 1'b1, w[k*BUS_W +: BUS_W], '1, 1'b1);
        push_done(last_load, cap + 7);
        drive_req(64'h2000, 1'b1, w, '1);
        @(posedge clk); #1;
        vec_mem_req = 1'b0; vec_mem_wdata = '1; vec_mem_addr = 64'hFFFF_0000; vec_mem_be = '0;
        @(posedge clk); #1;
        bus_if.bus_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus_if.bus_ready = 1'b1;
        wait_drain("store_stall", 60);

        // Sparse store: only beats 0 and 3 enabled
        w = mk_wdata(32'h5500_0000);
        be = '0;
        be[15:0]  = 16'h8001;
        be[63:48] = 16'h0F0F;
        @(posedge clk); #1;
        cap = cyc + 1;
        push_beat(64'h3000, 1'b1, w[127:0], 16'h8001, 1'b1);
        push_beat(64'h3030, 1'b1, w[511:384], 16'h0F0F, 1'b1);
        push_done(last_load, cap + 2);
        drive_req(64'h3010, 1'b1, w, be);
        @(posedge clk); #1;
        vec_mem_req = 1'b0;
        wait_drain("store_sparse", 40);

        // Store with no enabled bytes: no bus traffic, immediate completion
        @(posedge clk); #1;
        cap = cyc + 1;
        push_done(last_load, cap);
        drive_req(64'h4000, 1'b1, mk_wdata(32'h1), '0);
        @(posedge clk); #1;
        vec_mem_req = 1'b0;
        wait_drain("store_empty", 20);

        // Reset while waiting for the beat-2 response
        data_tag = 32'hB0;
        rsp_limit = rsp_cnt + 2;
        @(posedge clk); #1;
        push_load_beats(64'h5000, 3);
        drive_req(64'h5000, 1'b0, '0, '1);
        @(posedge clk); #1;
        vec_mem_req = 1'b0;
        begin
            int n = 0;
            while (exp_beats.size() != 0 && n < 60) begin @(posedge clk); #1; n++; end
            checks++;
            if (n >= 60) begin
                errors++;
                $display("FAIL abort_setup_timeout: got %0d beats pending expected 0", exp_beats.size());
            end
        end
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_rst_bus_valid", VLEN'(bus_if.bus_valid), '0);
        chk("async_rst_busy", VLEN'(busy), '0);
        chk("async_rst_rdata", vec_mem_rdata, '0);
        chk("async_rst_bus_addr", VLEN'(bus_if.bus_addr), '0);
        rsp_limit = 32'h7fff_ffff;
        @(posedge clk); #1;
        rst = 1'b0;
        spur_req++;
        repeat (4) @(posedge clk);
        #1;
        chk("late_rvalid_busy", VLEN'(busy), '0);
        chk("late_rvalid_rdata", vec_mem_rdata, '0);

        // Fresh load after reset
        @(posedge clk); #1;
        cap = cyc + 1;
        push_load_beats(64'h5000, 4);
        push_done(exp_load(32'hB0), cap + 8);
        drive_req(64'h5000, 1'b0, '0, '1);
        @(posedge clk); #1;
        vec_mem_req = 1'b0;
        wait_drain("load_after_rst", 60);

        // Stray rvalid in IDLE must not leak into the result
        spur_req++;
        repeat (4) @(posedge clk);
        #1;
        chk("spurious_rvalid_rdata", vec_mem_rdata, exp_load(32'hB0));
        chk("spurious_rvalid_busy", VLEN'(busy), '0);

        // Back-to-back loads with req held high; exactly one IDLE cycle between them
        data_tag = 32'hC0;
        @(posedge clk); #1;
        cap = cyc + 1;
        push_load_beats(64'h6000, 4);
        push_done(exp_load(32'hC0), cap + 8);
        push_load_beats(64'h7000, 4);
        push_done(exp_load(32'hD0), cap + 18);
        drive_req(64'h6000, 1'b0, '0, '1);
        wait_cyc(cap + 8);
        vec_mem_addr = 64'h7000;
        data_tag = 32'hD0;
        wait_cyc(cap + 10);
        vec_mem_req = 1'b0;
        wait_drain("back_to_back", 80);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
